edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Captures rising edges on `WIDTH` asynchronous-event lines that have already been synchronized to `clk`, and latches each one as a pending event. A round-robin scheduler presents the pending events one at a time to a single consumer over a valid/ready handshake. It sits between a bank of edge detectors and a shared event consumer, such as an interrupt dispatcher or a command sequencer, so that no edge is lost while the consumer is busy.

## Interface
- `WIDTH`, default 8: number of event lines; legal range 2..32.
- `IDX_W`, default `$clog2(WIDTH)`: width of the event index. Derived; do not override.

- `clk`  in  1  clock.
- `anrst`  in  1  reset, asynchronous, active-low.
- `in`  in  `WIDTH`  event lines, synchronous to `clk`.
- `mask`  in  `WIDTH`  per-line capture enable (1 = capture).
- `ev_valid`  out  1  an event is offered.
- `ev_ready`  in  1  consumer accepts the offered event.
- `ev_idx`  out  `IDX_W`  index of the offered line.
- `pending`  out  `WIDTH`  pending-event vector.
- `ovf`  out  `WIDTH`  sticky overflow flags.
- `ovf_clr`  in  `WIDTH`  per-bit overflow clear, one-cycle pulse.

## Operation
- **Edge detection**
  - Delay register `in_d`, reset value 0.
  - `rise = in & ~in_d & mask`.
  - A line held high through reset release produces exactly one event on the first clock edge after release.
- **Pending register**
  - `pend <= (pend | rise) & ~(acc & ~rise)`.
  - `acc` is the one-hot of `ev_idx` when `ev_valid & ev_ready`, else 0.
  - A new rise on the bit being accepted in the same cycle keeps that bit pending. It is a new event, not an overflow.
- **Mask** gates capture only. Bits already pending remain pending and are still scheduled after their mask bit clears.
- **Scheduler FSM**, two states:
  - **IDLE**: `ev_valid=0`. If `pend != 0`, select the first set bit searching upward from `ptr`, wrapping `WIDTH-1` to 0. Register the result into `ev_idx`, set `ev_valid=1`, and go to OFFER.
  - **OFFER**: `ev_valid=1`. `ev_idx` is held stable until a handshake.
    - On handshake: `ptr <= ev_idx+1`, wrapping to 0 after `WIDTH-1`.
    - If `pend & ~acc` is nonzero, select the next event from the new `ptr` in the same cycle and stay in OFFER (back-to-back offer).
    - Otherwise go to IDLE.
  - `ptr` is an `IDX_W`-bit register, reset value 0. It is never allowed to hold a value of `WIDTH` or more.
- **Handshake rules**
  - `ev_valid` never deasserts without a handshake, except on reset.
  - `ev_idx` does not change while `ev_valid=1 & ev_ready=0`.
  - `ev_ready` while `ev_valid=0` is ignored.
- `pending` output equals `pend`. The offered bit remains set in `pending` until its handshake.
- **Reset** (any time, including mid-offer) clears all state. All captured events are discarded.

## Timing
- Reset values: `ev_valid=0`, `ev_idx=0`, `pending=0`, `ovf=0`, FSM in IDLE, `ptr=0`.
- Capture latency: with `in` rising before clock edge k, `pending` is set after edge k. `ev_valid` asserts after edge k+1, provided the FSM was in IDLE with no other events.
- Throughput: one event per cycle when `ev_ready` is held high and events are pending.
- Accept-to-clear: the `pending` bit clears at the edge on which the handshake occurs.
- All outputs are registered. There is no combinational path from `ev_ready` or `in` to any output.

## Configuration
- Macro: `EDGE_EVENT_ARBITER_OVF_EN`.
- **Defined**
  - `ovf[i]` sets when `rise[i]=1`, `pend[i]=1`, and bit i is not being accepted in the same cycle.
  - `ovf[i]` clears on `ovf_clr[i]`. If set and clear occur in the same cycle, set wins.
  - The lost event is not re-queued.
- **Undefined**
  - No overflow logic is synthesized.
  - `ovf` is tied to 0 and `ovf_clr` is ignored.
  - The port list is identical in both builds.

## Test plan
- **Single event:** `WIDTH=8`, `ev_ready=1`, pulse `in[3]` → `pending=0x08` one edge later, then `ev_valid=1` with `ev_idx=3`. After the handshake, `pending=0` and `ev_valid=0`.
- **Round-robin with wrap:** `ev_ready=0`; raise `in[1]`, `in[5]`, and `in[7]` in one cycle; set `ptr=6` via a prior accept of idx 5. Then hold `ev_ready=1` → `ev_idx` sequence 7, 1, 5 on consecutive cycles, then `ev_valid=0`.
- **Backpressure:** offer idx 2, hold `ev_ready=0` for 10 cycles while `in[4]` rises → `ev_idx` stays 2 and `pending=0x14`. On the first handshake the next offer is idx 4.
- **Overflow (macro defined):** with bit 6 pending and unaccepted, a second rise on `in[6]` → `ovf[6]=1`. Pulsing `ovf_clr[6]` → `ovf[6]=0`. With the macro undefined, `ovf` stays 0.
- **Rise during accept of same bit:** accept idx 0 in the same cycle that `in[0]` rises → `pending[0]` stays 1, `ovf[0]` stays 0, and idx 0 is offered again later.
- **Mask and reset:** `mask[2]=0` while `in[2]` rises → no pending bit and no offer. Asserting `anrst=0` mid-offer → `ev_valid`, `pending`, and `ovf` are 0 immediately. After release, a line held high generates one event.

Source files
------------

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event channel between edge_event_arbiter (master) and its consumer (slave).
interface edge_event_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_idx;

    modport master (output ev_valid, output ev_idx, input ev_ready);
    modport slave  (input ev_valid, input ev_idx, output ev_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Latches masked rising edges as pending events and offers them round-robin over a valid/ready channel.
// Optional sticky overflow flags are built when EDGE_EVENT_ARBITER_OVF_EN is defined.
module edge_event_arbiter #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 anrst,
    input  logic [WIDTH-1:0]     i_in,
    input  logic [WIDTH-1:0]     i_mask,
    edge_event_arbiter_if.master io_ev,
    output logic [WIDTH-1:0]     o_pending,
    output logic [WIDTH-1:0]     o_ovf,
    input  logic [WIDTH-1:0]     i_ovf_clr
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_in_d;
    logic [WIDTH-1:0] r_pend;
    state_t           r_state;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;

    logic [WIDTH-1:0] w_rise;
    logic             w_hs;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_rem;
    logic [IDX_W-1:0] w_ptr_inc;
    state_t           w_state_nx;
    logic             w_valid_nx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [IDX_W-1:0] w_ptr_nx;

    function automatic logic [WIDTH-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] v;
        v      = {WIDTH{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set bit of req searching upward from base, wrapping WIDTH-1 to 0.
    function automatic logic [IDX_W-1:0] f_rr_pick(input logic [WIDTH-1:0] req,
                                                   input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] j_idx;
        logic             hit;
        int               j;
        sel = base;
        hit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            j = int'(base) + i;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end else begin
                j = j;
            end
            j_idx = IDX_W'(j);
            if (!hit && req[j_idx]) begin
                sel = j_idx;
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return sel;
    endfunction

    assign w_rise    = i_in & ~r_in_d & i_mask;
    assign w_hs      = r_valid & io_ev.ev_ready;
    assign w_acc     = w_hs ? f_onehot(r_idx) : {WIDTH{1'b0}};
    assign w_rem     = r_pend & ~w_acc;
    assign w_ptr_inc = (r_idx == IDX_W'(WIDTH - 1)) ? {IDX_W{1'b0}} : (r_idx + {{(IDX_W-1){1'b0}}, 1'b1});

    // Edge-detect delay line and pending set/clear; a rise on the accepted bit keeps it pending.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_in_d <= {WIDTH{1'b0}};
            r_pend <= {WIDTH{1'b0}};
        end else begin
            r_in_d <= i_in;
            r_pend <= (r_pend | w_rise) & ~(w_acc & ~w_rise);
        end
    end

    // Scheduler next-state: offer from ptr, back-to-back while events remain after a handshake.
    always_comb begin
        w_state_nx = r_state;
        w_valid_nx = r_valid;
        w_idx_nx   = r_idx;
        w_ptr_nx   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != {WIDTH{1'b0}}) begin
                    w_idx_nx   = f_rr_pick(r_pend, r_ptr);
                    w_valid_nx = 1'b1;
                    w_state_nx = ST_OFFER;
                end else begin
                    w_valid_nx = 1'b0;
                end
            end
            ST_OFFER: begin
                if (w_hs) begin
                    w_ptr_nx = w_ptr_inc;
                    if (w_rem != {WIDTH{1'b0}}) begin
                        w_idx_nx   = f_rr_pick(w_rem, w_ptr_inc);
                        w_valid_nx = 1'b1;
                        w_state_nx = ST_OFFER;
                    end else begin
                        w_valid_nx = 1'b0;
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_valid_nx = 1'b1;
                end
            end
            default: begin
                w_valid_nx = 1'b0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Scheduler state register; ev_valid/ev_idx come straight from flops.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_idx   <= {IDX_W{1'b0}};
            r_ptr   <= {IDX_W{1'b0}};
        end else begin
            r_state <= w_state_nx;
            r_valid <= w_valid_nx;
            r_idx   <= w_idx_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

`ifdef EDGE_EVENT_ARBITER_OVF_EN
    logic [WIDTH-1:0] r_ovf;

    // Sticky overflow: a rise on an already-pending, not-accepted bit; set beats clear.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_ovf <= {WIDTH{1'b0}};
        end else begin
            r_ovf <= (r_ovf & ~i_ovf_clr) | (w_rise & r_pend & ~w_acc);
        end
    end

    assign o_ovf = r_ovf;
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ^i_ovf_clr;
    assign o_ovf            = {WIDTH{1'b0}};
`endif

    assign o_pending      = r_pend;
    assign io_ev.ev_valid = r_valid;
    assign io_ev.ev_idx   = r_idx;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: stimulus pushes expected indices, a monitor pops them on each handshake.
module tb_edge_event_arbiter;

    localparam int WIDTH = 8;
    localparam int IDX_W = $clog2(WIDTH);

    logic             clk;
    logic             anrst;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] pending_s;
    logic [WIDTH-1:0] ovf_s;
    logic [WIDTH-1:0] ovf_clr_s;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

`ifdef EDGE_EVENT_ARBITER_OVF_EN
    localparam logic [WIDTH-1:0] OVF6_EXP = 8'h40;
`else
    localparam logic [WIDTH-1:0] OVF6_EXP = 8'h00;
`endif

    edge_event_arbiter_if #(.WIDTH(WIDTH)) ev_if ();

    edge_event_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .anrst     (anrst),
        .i_in      (in_s),
        .i_mask    (mask_s),
        .io_ev     (ev_if),
        .o_pending (pending_s),
        .o_ovf     (ovf_s),
        .i_ovf_clr (ovf_clr_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake seen must match the oldest expected index.
    always @(negedge clk) begin
        if (anrst && ev_if.ev_valid && ev_if.ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=%0d expected=none", ev_if.ev_idx);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(ev_if.ev_idx) != e) begin
                    failures++;
                    $display("FAIL event_idx actual=%0d expected=%0d", ev_if.ev_idx, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        anrst          = 1'b0;
        in_s           = 8'h00;
        mask_s         = 8'hFF;
        ovf_clr_s      = 8'h00;
        ev_if.ev_ready = 1'b0;
        step();
        step();
        anrst = 1'b1;
        chk("reset_valid",   32'(ev_if.ev_valid), 32'h0);
        chk("reset_idx",     32'(ev_if.ev_idx),   32'h0);
        chk("reset_pending", 32'(pending_s),      32'h0);
        chk("reset_ovf",     32'(ovf_s),          32'h0);

        // Single event on line 3
        ev_if.ev_ready = 1'b1;
        in_s = 8'h08;
        exp_q.push_back(3);
        step();
        in_s = 8'h00;
        chk("single_pending", 32'(pending_s), 32'h08);
        chk("single_valid_lat", 32'(ev_if.ev_valid), 32'h0);
        step();
        chk("single_valid", 32'(ev_if.ev_valid), 32'h1);
        chk("single_idx",   32'(ev_if.ev_idx),   32'h3);
        step();
        chk("single_clear_pending", 32'(pending_s), 32'h0);
        chk("single_clear_valid",   32'(ev_if.ev_valid), 32'h0);

        // Round-robin with wrap: accept idx 5 first so ptr becomes 6
        ev_if.ev_ready = 1'b0;
        in_s = 8'h20;
        exp_q.push_back(5);
        step();
        in_s = 8'h00;
        step();
        ev_if.ev_ready = 1'b1;
        step();
        ev_if.ev_ready = 1'b0;
        in_s = 8'hA2;
        exp_q.push_back(7);
        exp_q.push_back(1);
        exp_q.push_back(5);
        step();
        in_s = 8'h00;
        step();
        chk("rr_pending", 32'(pending_s), 32'hA2);
        chk("rr_first_idx", 32'(ev_if.ev_idx), 32'h7);
        ev_if.ev_ready = 1'b1;
        step();
        chk("rr_second_idx", 32'(ev_if.ev_idx), 32'h1);
        step();
        chk("rr_third_idx", 32'(ev_if.ev_idx), 32'h5);
        step();
        chk("rr_done_valid",   32'(ev_if.ev_valid), 32'h0);
        chk("rr_done_pending", 32'(pending_s),      32'h0);
        ev_if.ev_ready = 1'b0;

        // Backpressure: idx 2 held while line 4 rises
        in_s = 8'h04;
        exp_q.push_back(2);
        exp_q.push_back(4);
        step();
        in_s = 8'h00;
        step();
        in_s = 8'h10;
        step();
        in_s = 8'h00;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("bp_idx_stable", 32'(ev_if.ev_idx), 32'h2);
        end
        chk("bp_valid",   32'(ev_if.ev_valid), 32'h1);
        chk("bp_pending", 32'(pending_s),      32'h14);
        ev_if.ev_ready = 1'b1;
        step();
        chk("bp_next_valid", 32'(ev_if.ev_valid), 32'h1);
        chk("bp_next_idx",   32'(ev_if.ev_idx),   32'h4);
        step();
        ev_if.ev_ready = 1'b0;

        // Overflow on line 6
        in_s = 8'h40;
        exp_q.push_back(6);
        step();
        in_s = 8'h00;
        step();
        in_s = 8'h40;
        step();
        in_s = 8'h00;
        chk("ovf_set",     32'(ovf_s),     32'(OVF6_EXP));
        chk("ovf_pending", 32'(pending_s), 32'h40);
        ovf_clr_s = 8'h40;
        step();
        ovf_clr_s = 8'h00;
        chk("ovf_clear", 32'(ovf_s), 32'h0);
        ev_if.ev_ready = 1'b1;
        step();
        chk("ovf_drain_pending", 32'(pending_s), 32'h0);
        step();
        chk("ovf_no_requeue", 32'(ev_if.ev_valid), 32'h0);
        ev_if.ev_ready = 1'b0;

        // Rise on line 0 during its own accept
        in_s = 8'h01;
        exp_q.push_back(0);
        exp_q.push_back(0);
        step();
        in_s = 8'h00;
        step();
        chk("same_offer_idx", 32'(ev_if.ev_idx), 32'h0);
        ev_if.ev_ready = 1'b1;
        in_s = 8'h01;
        step();
        in_s = 8'h00;
        chk("same_pending_kept", 32'(pending_s), 32'h01);
        chk("same_no_ovf",       32'(ovf_s),     32'h0);
        step();
        chk("same_reoffer_valid", 32'(ev_if.ev_valid), 32'h1);
        step();
        chk("same_done_pending", 32'(pending_s), 32'h0);
        ev_if.ev_ready = 1'b0;

        // Mask blocks capture on line 2
        mask_s = 8'hFB;
        in_s = 8'h04;
        step();
        in_s = 8'h00;
        step();
        chk("mask_pending", 32'(pending_s), 32'h0);
        chk("mask_valid",   32'(ev_if.ev_valid), 32'h0);
        mask_s = 8'hFF;

        // Reset mid-offer, then a line held high through release
        in_s = 8'h02;
        step();
        in_s = 8'h00;
        step();
        chk("rst_pre_valid", 32'(ev_if.ev_valid), 32'h1);
        in_s  = 8'h10;
        anrst = 1'b0;
        #1;
        chk("rst_async_valid",   32'(ev_if.ev_valid), 32'h0);
        chk("rst_async_pending", 32'(pending_s),      32'h0);
        chk("rst_async_ovf",     32'(ovf_s),          32'h0);
        step();
        step();
        anrst = 1'b1;
        ev_if.ev_ready = 1'b1;
        exp_q.push_back(4);
        step();
        chk("rst_held_pending", 32'(pending_s), 32'h10);
        step();
        chk("rst_held_idx", 32'(ev_if.ev_idx), 32'h4);
        step();
        step();
        step();
        chk("rst_held_once_pending", 32'(pending_s),      32'h0);
        chk("rst_held_once_valid",   32'(ev_if.ev_valid), 32'h0);
        in_s = 8'h00;
        ev_if.ev_ready = 1'b0;
        step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
